calc_result_display: RTL

Downstream display stage for the calculator datapath. Captures the 8-bit `result` and the `op` that produced it on a load strobe. Converts the value to sign plus three BCD digits with a sequential double-dabble engine, then drives a 4-digit, time-multiplexed, common-anode 7-segment display with leading-zero blanking.

---
 rtl/calc_result_display_if.sv | 24 ++
 rtl/calc_result_display.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/calc_result_display_if.sv
// Handshake and display bus between the calculator datapath and its result display stage.
interface calc_result_display_if;
  logic [7:0] result;
  logic [1:0] op;
  logic       load;
  logic       busy;
  logic       done;
  logic       neg;
  logic [3:0] bcd_h;
  logic [3:0] bcd_t;
  logic [3:0] bcd_o;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output result, op, load,
    input  busy, done, neg, bcd_h, bcd_t, bcd_o, seg, an
  );

  modport slave (
    input  result, op, load,
    output busy, done, neg, bcd_h, bcd_t, bcd_o, seg, an
  );
endinterface

// File: rtl/calc_result_display.sv
// Result display stage: sign/magnitude capture, sequential double-dabble to BCD,
// and a time-multiplexed common-anode 4-digit 7-segment driver with zero blanking.
module calc_result_display #(
  parameter int REFRESH_DIV = 1000
) (
  input logic                  clk,
  input logic                  rst_n,
  calc_result_display_if.slave bus
);
  localparam int DATA_W = 8;
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic {IDLE, CONV} state_t;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
    return {add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
  endfunction

  // Only a negative subtraction result is reported as signed; 8'h80 maps to 128.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] r,
                                                  input logic              is_neg);
    logic signed [DATA_W-1:0] r_s;
    r_s = signed'(r);
    return is_neg ? unsigned'(-r_s) : r;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         iter;
  logic               accept;
  logic               last_iter;
  logic               sub_neg;
  logic [DATA_W-1:0]  mag_sr;
  logic [11:0]        work_bcd;
  logic [11:0]        bcd_adj;
  logic [11:0]        bcd_shift;
  logic               sign_pend;

  logic               done_r;
  logic               neg_r;
  logic [3:0]         bcd_h_r;
  logic [3:0]         bcd_t_r;
  logic [3:0]         bcd_o_r;

  logic [CNT_W-1:0]   refresh_cnt;
  logic [1:0]         slot;
  logic [6:0]         seg_r;
  logic [6:0]         seg_nxt;
  logic [3:0]         an_r;
  logic [3:0]         an_nxt;

  assign sub_neg   = (bus.op == 2'b01) && bus.result[DATA_W-1];
  assign accept    = (state == IDLE) && bus.load;
  assign last_iter = (state == CONV) && (iter == 3'd7);
  assign bcd_adj   = dabble_adjust(work_bcd);
  assign bcd_shift = {bcd_adj[10:0], mag_sr[DATA_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.load) state_nxt = CONV;
      CONV:    if (iter == 3'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and committed outputs; committed digits only move on the final iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter    <= 3'd0;
      done_r  <= 1'b0;
      neg_r   <= 1'b0;
      bcd_h_r <= 4'd0;
      bcd_t_r <= 4'd0;
      bcd_o_r <= 4'd0;
    end else begin
      done_r <= last_iter;
      if (accept)             iter <= 3'd0;
      else if (state == CONV) iter <= iter + 3'd1;
      if (last_iter) begin
        bcd_h_r <= bcd_shift[11:8];
        bcd_t_r <= bcd_shift[7:4];
        bcd_o_r <= bcd_shift[3:0];
        neg_r   <= sign_pend;
      end
    end
  end

  // Conversion datapath; working state is reloaded on every accepted load.
  always_ff @(posedge clk) begin
    if (accept) begin
      mag_sr    <= magnitude(bus.result, sub_neg);
      work_bcd  <= 12'd0;
      sign_pend <= sub_neg;
    end else if (state == CONV) begin
      mag_sr    <= {mag_sr[DATA_W-2:0], 1'b0};
      work_bcd  <= bcd_shift;
    end
  end

  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = 4'b1111;
    unique case (slot)
      2'd0: begin
        seg_nxt = digit_seg(bcd_o_r);
        an_nxt  = 4'b1110;
      end
      2'd1: begin
        seg_nxt = (bcd_h_r == 4'd0 && bcd_t_r == 4'd0) ? SEG_BLANK : digit_seg(bcd_t_r);
        an_nxt  = 4'b1101;
      end
      2'd2: begin
        seg_nxt = (bcd_h_r == 4'd0) ? SEG_BLANK : digit_seg(bcd_h_r);
        an_nxt  = 4'b1011;
      end
      default: begin
        seg_nxt = neg_r ? SEG_MINUS : SEG_BLANK;
        an_nxt  = 4'b0111;
      end
    endcase
  end

  // Scan timing runs free of the conversion FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      slot        <= 2'd0;
      seg_r       <= SEG_BLANK;
      an_r        <= 4'b1111;
    end else begin
      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        slot        <= slot + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      seg_r <= seg_nxt;
      an_r  <= an_nxt;
    end
  end

  assign bus.busy  = (state == CONV);
  assign bus.done  = done_r;
  assign bus.neg   = neg_r;
  assign bus.bcd_h = bcd_h_r;
  assign bus.bcd_t = bcd_t_r;
  assign bus.bcd_o = bcd_o_r;
  assign bus.seg   = seg_r;
  assign bus.an    = an_r;
endmodule
